mem_wb: RTL and testbench

- Load/store completion stage directly downstream of the memory address-generation stage.
- Consumes the delayed issue triple (en, pc, 72-bit decoded inst), the L1D access address and the L1D read data.
- Loads: aligns and extends read data and writes it back to the register file.
- Stores: queues them in a small store buffer that drains to the L1D write port, with optional store-to-load forwarding.

---
 rtl/mem_wb.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_wb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// Load/store completion stage: aligns load data for writeback and queues stores in a
// small FIFO that drains to the L1D write port. Define MEM_WB_STLF_EN to enable store-to-load forwarding.
module mem_wb #(
    parameter int SB_DEPTH = 4,
    parameter int SB_AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_en_i,
    input  logic [31:0]   mem_pc_i,
    input  logic [71:0]   mem_inst_i,
    input  logic [31:0]   acc_addr_i,
    input  logic [31:0]   l1d_rdata_i,
    input  logic [1023:0] reg_rdata_i,
    output logic          reg_we_o,
    output logic [4:0]    reg_waddr_o,
    output logic [31:0]   reg_wdata_o,
    output logic          done_o,
    output logic [31:0]   done_pc_o,
    output logic          misalign_o,
    output logic          l1d_we_o,
    output logic [31:0]   l1d_waddr_o,
    output logic [31:0]   l1d_wdata_o,
    output logic [3:0]    l1d_wstrb_o,
    input  logic          l1d_wready_i,
    output logic          stall_o,
    output logic          overflow_o
);

    localparam logic [6:0]       OP_LOAD  = 7'b0000011;
    localparam logic [6:0]       OP_STORE = 7'b0100011;
    localparam logic [SB_AW:0]   CNT_FULL = (SB_AW+1)'(SB_DEPTH);
    localparam logic [SB_AW:0]   CNT_ONE  = (SB_AW+1)'(32'd1);
    localparam logic [SB_AW:0]   CNT_ZERO = (SB_AW+1)'(32'd0);
    localparam logic [SB_AW-1:0] PTR_ONE  = SB_AW'(32'd1);
    localparam logic [SB_AW-1:0] PTR_ZERO = SB_AW'(32'd0);

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h000000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = w;
        endcase
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        strb_mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs2_s;
    logic        inst_we_s;
    logic [31:0] rs2_val_s;
    logic        unused_s;

    assign opcode_s  = mem_inst_i[71:65];
    assign funct3_s  = mem_inst_i[64:62];
    assign rd_s      = mem_inst_i[54:50];
    assign rs2_s     = mem_inst_i[44:40];
    assign inst_we_s = mem_inst_i[39];
    assign rs2_val_s = reg_rdata_i[{rs2_s, 5'b00000} +: 32];
    assign unused_s  = ^{mem_inst_i[61:55], mem_inst_i[49:45], mem_inst_i[38:0]};

    logic [31:0] addr_q;
    logic        is_load_s, is_store_s, misal_s;
    logic        ld_ok_s, push_s, pop_s, full_s, push_ok_s, ovf_set_s;
    logic [31:0] st_data_s, load_word_s;
    logic [3:0]  st_strb_s;

    logic [29:0] sb_addr_q [SB_DEPTH];
    logic [31:0] sb_data_q [SB_DEPTH];
    logic [3:0]  sb_strb_q [SB_DEPTH];
    logic [SB_AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [SB_AW:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic        reg_we_q, reg_we_d, done_q, done_d, misal_q, misal_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d, done_pc_q, done_pc_d;

    // Classify the issuing instruction and flag misaligned halfword/word accesses.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        misal_s    = 1'b0;
        if (mem_en_i && opcode_s == OP_LOAD) begin
            case (funct3_s)
                3'b000, 3'b100: is_load_s = 1'b1;
                3'b001, 3'b101: begin is_load_s = 1'b1; misal_s = addr_q[0]; end
                3'b010:         begin is_load_s = 1'b1; misal_s = (addr_q[1:0] != 2'b00); end
                default:        is_load_s = 1'b0;
            endcase
        end else if (mem_en_i && opcode_s == OP_STORE) begin
            case (funct3_s)
                3'b000:  is_store_s = 1'b1;
                3'b001:  begin is_store_s = 1'b1; misal_s = addr_q[0]; end
                3'b010:  begin is_store_s = 1'b1; misal_s = (addr_q[1:0] != 2'b00); end
                default: is_store_s = 1'b0;
            endcase
        end else begin
            misal_s = 1'b0;
        end
    end

    // Position store data in its byte lanes and build the matching strobes.
    always_comb begin
        case (funct3_s[1:0])
            2'b00: begin
                st_data_s = {4{rs2_val_s[7:0]}};
                st_strb_s = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                st_data_s = {2{rs2_val_s[15:0]}};
                st_strb_s = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data_s = rs2_val_s;
                st_strb_s = 4'b1111;
            end
        endcase
    end

    assign ld_ok_s   = is_load_s & ~misal_s;
    assign push_s    = is_store_s & ~misal_s;
    assign pop_s     = (count_q != CNT_ZERO) & l1d_wready_i;
    assign full_s    = (count_q == CNT_FULL);
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;

`ifdef MEM_WB_STLF_EN
    logic [SB_AW-1:0] fwd_idx_s;
    logic             fwd_hit_s;
    logic [31:0]      fwd_mask_s;
    // Merge buffered store bytes over the L1D word, oldest first so the youngest wins.
    // A store's entry is written at the edge closing its issue cycle, so the next load sees it here.
    always_comb begin
        load_word_s = l1d_rdata_i;
        fwd_idx_s   = PTR_ZERO;
        fwd_hit_s   = 1'b0;
        fwd_mask_s  = 32'h0000_0000;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_idx_s   = head_q + SB_AW'(k);
            fwd_hit_s   = ((SB_AW+1)'(k) < count_q) && (sb_addr_q[fwd_idx_s] == addr_q[31:2]);
            fwd_mask_s  = fwd_hit_s ? strb_mask(sb_strb_q[fwd_idx_s]) : 32'h0000_0000;
            load_word_s = (load_word_s & ~fwd_mask_s) | (sb_data_q[fwd_idx_s] & fwd_mask_s);
        end
    end
`else
    assign load_word_s = l1d_rdata_i;
`endif

    // Next-state values of the registered writeback/completion outputs.
    always_comb begin
        reg_we_d    = ld_ok_s & inst_we_s & (rd_s != 5'd0);
        reg_waddr_d = ld_ok_s ? rd_s : 5'd0;
        reg_wdata_d = ld_ok_s ? load_extend(load_word_s, funct3_s, addr_q[1:0]) : 32'h0000_0000;
        done_d      = mem_en_i;
        done_pc_d   = mem_en_i ? mem_pc_i : 32'h0000_0000;
        misal_d     = (is_load_s | is_store_s) & misal_s;
    end

    // Next-state store buffer pointers, occupancy and sticky overflow.
    always_comb begin
        head_d     = pop_s ? head_q + PTR_ONE : head_q;
        tail_d     = push_ok_s ? tail_q + PTR_ONE : tail_q;
        overflow_d = overflow_q | ovf_set_s;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pipeline and store buffer control registers; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= 32'h0000_0000;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= 5'd0;
            reg_wdata_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            done_pc_q   <= 32'h0000_0000;
            misal_q     <= 1'b0;
            head_q      <= PTR_ZERO;
            tail_q      <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
        end else begin
            addr_q      <= acc_addr_i;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            done_q      <= done_d;
            done_pc_q   <= done_pc_d;
            misal_q     <= misal_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Store buffer storage; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            sb_addr_q[tail_q] <= addr_q[31:2];
            sb_data_q[tail_q] <= st_data_s;
            sb_strb_q[tail_q] <= st_strb_s;
        end
    end

    // Present the head entry to the L1D write port; an empty buffer drives zeros.
    always_comb begin
        if (count_q != CNT_ZERO) begin
            l1d_we_o    = 1'b1;
            l1d_waddr_o = {sb_addr_q[head_q], 2'b00};
            l1d_wdata_o = sb_data_q[head_q];
            l1d_wstrb_o = sb_strb_q[head_q];
        end else begin
            l1d_we_o    = 1'b0;
            l1d_waddr_o = 32'h0000_0000;
            l1d_wdata_o = 32'h0000_0000;
            l1d_wstrb_o = 4'b0000;
        end
    end

`ifdef MEM_WB_STLF_EN
    assign stall_o = (count_q >= CNT_FULL - CNT_ONE);
`else
    // Without forwarding, hold off loads until every older store has drained.
    assign stall_o = (count_q >= CNT_FULL - CNT_ONE) | (count_q != CNT_ZERO) | push_s;
`endif

    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign done_o      = done_q;
    assign done_pc_o   = done_pc_q;
    assign misalign_o  = misal_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for mem_wb; expected values are hand-computed.
module tb_mem_wb;

    logic          clk;
    logic          rst;
    logic          mem_en_i;
    logic [31:0]   mem_pc_i;
    logic [71:0]   mem_inst_i;
    logic [31:0]   acc_addr_i;
    logic [31:0]   l1d_rdata_i;
    logic [1023:0] reg_rdata_i;
    logic          reg_we_o;
    logic [4:0]    reg_waddr_o;
    logic [31:0]   reg_wdata_o;
    logic          done_o;
    logic [31:0]   done_pc_o;
    logic          misalign_o;
    logic          l1d_we_o;
    logic [31:0]   l1d_waddr_o;
    logic [31:0]   l1d_wdata_o;
    logic [3:0]    l1d_wstrb_o;
    logic          l1d_wready_i;
    logic          stall_o;
    logic          overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MEM_WB_STLF_EN
    localparam logic STLF = 1'b1;
`else
    localparam logic STLF = 1'b0;
`endif

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;

    mem_wb dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en_i     (mem_en_i),
        .mem_pc_i     (mem_pc_i),
        .mem_inst_i   (mem_inst_i),
        .acc_addr_i   (acc_addr_i),
        .l1d_rdata_i  (l1d_rdata_i),
        .reg_rdata_i  (reg_rdata_i),
        .reg_we_o     (reg_we_o),
        .reg_waddr_o  (reg_waddr_o),
        .reg_wdata_o  (reg_wdata_o),
        .done_o       (done_o),
        .done_pc_o    (done_pc_o),
        .misalign_o   (misalign_o),
        .l1d_we_o     (l1d_we_o),
        .l1d_waddr_o  (l1d_waddr_o),
        .l1d_wdata_o  (l1d_wdata_o),
        .l1d_wstrb_o  (l1d_wstrb_o),
        .l1d_wready_i (l1d_wready_i),
        .stall_o      (stall_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs2);
        logic [71:0] v;
        v        = 72'h0;
        v[71:65] = op;
        v[64:62] = f3;
        v[54:50] = rd;
        v[44:40] = rs2;
        v[39]    = 1'b1;
        return v;
    endfunction

    // Address cycle, then issue cycle; returns #1 after the edge that registers the result.
    task automatic issue(input logic [71:0] inst, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic wa, input logic wb);
        acc_addr_i   = addr;
        mem_en_i     = 1'b0;
        l1d_wready_i = wa;
        @(posedge clk); #1;
        mem_en_i     = 1'b1;
        mem_pc_i     = pc;
        mem_inst_i   = inst;
        l1d_rdata_i  = rdata;
        l1d_wready_i = wb;
        @(posedge clk); #1;
        mem_en_i     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; mem_en_i = 1'b0; mem_pc_i = 32'h0; mem_inst_i = 72'h0;
        acc_addr_i = 32'h0; l1d_rdata_i = 32'h0; l1d_wready_i = 1'b0;
        reg_rdata_i = {1024{1'b0}};
        reg_rdata_i[32*5  +: 32] = 32'h0000_00AB;
        reg_rdata_i[32*6  +: 32] = 32'h0000_BEEF;
        reg_rdata_i[32*7  +: 32] = 32'hA000_0007;
        reg_rdata_i[32*8  +: 32] = 32'hA000_0008;
        reg_rdata_i[32*9  +: 32] = 32'hA000_0009;
        reg_rdata_i[32*10 +: 32] = 32'hA000_000A;
        reg_rdata_i[32*11 +: 32] = 32'h1122_3344;
        reg_rdata_i[32*12 +: 32] = 32'h0000_0055;
        step(); step();
        rst = 1'b0;

        check("rst_reg_we",   32'(reg_we_o),   32'd0);
        check("rst_done",     32'(done_o),     32'd0);
        check("rst_wdata",    reg_wdata_o,     32'h0);
        check("rst_l1d_we",   32'(l1d_we_o),   32'd0);
        check("rst_stall",    32'(stall_o),    32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);

        issue(mk(OP_L, 3'b000, 5'd3, 5'd0), 32'h100, 32'h1003, 32'h80FF_1234, 1'b1, 1'b1);
        check("lb_wdata", reg_wdata_o, 32'hFFFF_FF80);
        check("lb_we",    32'(reg_we_o), 32'd1);
        check("lb_waddr", 32'(reg_waddr_o), 32'd3);
        check("lb_done",  32'(done_o), 32'd1);
        check("lb_pc",    done_pc_o, 32'h100);
        check("lb_mis",   32'(misalign_o), 32'd0);

        issue(mk(OP_L, 3'b100, 5'd3, 5'd0), 32'h104, 32'h1003, 32'h80FF_1234, 1'b1, 1'b1);
        check("lbu_wdata", reg_wdata_o, 32'h0000_0080);

        issue(mk(OP_L, 3'b001, 5'd4, 5'd0), 32'h108, 32'h2002, 32'h8001_0000, 1'b1, 1'b1);
        check("lh_wdata", reg_wdata_o, 32'hFFFF_8001);
        issue(mk(OP_L, 3'b101, 5'd4, 5'd0), 32'h10C, 32'h2002, 32'h8001_0000, 1'b1, 1'b1);
        check("lhu_wdata", reg_wdata_o, 32'h0000_8001);

        issue(mk(OP_L, 3'b010, 5'd4, 5'd0), 32'h110, 32'h2002, 32'h8001_0000, 1'b1, 1'b1);
        check("lw_mis",    32'(misalign_o), 32'd1);
        check("lw_done",   32'(done_o), 32'd1);
        check("lw_we",     32'(reg_we_o), 32'd0);
        check("lw_nopush", 32'(l1d_we_o), 32'd0);

        issue(mk(OP_L, 3'b010, 5'd0, 5'd0), 32'h114, 32'h2000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("x0_we",   32'(reg_we_o), 32'd0);
        check("x0_done", 32'(done_o), 32'd1);

        issue(mk(OP_R, 3'b000, 5'd7, 5'd0), 32'h118, 32'h0, 32'h0, 1'b1, 1'b1);
        check("other_done", 32'(done_o), 32'd1);
        check("other_pc",   done_pc_o, 32'h118);
        check("other_we",   32'(reg_we_o), 32'd0);
        check("other_mis",  32'(misalign_o), 32'd0);
        step();
        check("done_pulse", 32'(done_o), 32'd0);

        issue(mk(OP_S, 3'b000, 5'd0, 5'd5), 32'h200, 32'h3001, 32'h0, 1'b1, 1'b1);
        check("sb_we",    32'(l1d_we_o), 32'd1);
        check("sb_waddr", l1d_waddr_o, 32'h3000);
        check("sb_wstrb", 32'(l1d_wstrb_o), 32'h2);
        check("sb_wdata", l1d_wdata_o, 32'hABAB_ABAB);
        check("sb_done",  32'(done_o), 32'd1);
        check("sb_regwe", 32'(reg_we_o), 32'd0);
        step();
        check("sb_popped", 32'(l1d_we_o), 32'd0);
        check("sb_empty_data", l1d_wdata_o, 32'h0);

        issue(mk(OP_S, 3'b001, 5'd0, 5'd6), 32'h204, 32'h3002, 32'h0, 1'b1, 1'b1);
        check("sh_wstrb", 32'(l1d_wstrb_o), 32'hC);
        check("sh_wdata", l1d_wdata_o, 32'hBEEF_BEEF);
        step();
        check("sh_popped", 32'(l1d_we_o), 32'd0);

        // Fill with writes blocked, then overflow with a fifth store.
        issue(mk(OP_S, 3'b010, 5'd0, 5'd7), 32'h300, 32'h5000, 32'h0, 1'b0, 1'b0);
        check("fill1_stall", 32'(stall_o), STLF ? 32'd0 : 32'd1);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd8), 32'h304, 32'h5004, 32'h0, 1'b0, 1'b0);
        check("fill2_stall", 32'(stall_o), STLF ? 32'd0 : 32'd1);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd9), 32'h308, 32'h5008, 32'h0, 1'b0, 1'b0);
        check("fill3_stall", 32'(stall_o), 32'd1);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd10), 32'h30C, 32'h500C, 32'h0, 1'b0, 1'b0);
        check("fill4_ovf", 32'(overflow_o), 32'd0);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd11), 32'h310, 32'h5010, 32'h0, 1'b0, 1'b0);
        check("fill5_ovf", 32'(overflow_o), 32'd1);
        check("fill_head", l1d_waddr_o, 32'h5000);
        check("fill_strb", 32'(l1d_wstrb_o), 32'hF);
        l1d_wready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", l1d_waddr_o, 32'h5000 + 32'(4 * i));
            check("drain_data", l1d_wdata_o, 32'hA000_0007 + 32'(i));
            step();
        end
        check("drain_empty", 32'(l1d_we_o), 32'd0);
        check("drain_stall", 32'(stall_o), 32'd0);
        check("ovf_sticky",  32'(overflow_o), 32'd1);

        // Reset while two stores wait with a write handshake pending.
        issue(mk(OP_S, 3'b010, 5'd0, 5'd7), 32'h400, 32'h7000, 32'h0, 1'b0, 1'b0);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd8), 32'h404, 32'h7004, 32'h0, 1'b0, 1'b0);
        check("pre_rst_we", 32'(l1d_we_o), 32'd1);
        rst = 1'b1;
        l1d_wready_i = 1'b1;
        step();
        check("mid_rst_we",    32'(l1d_we_o), 32'd0);
        check("mid_rst_stall", 32'(stall_o), 32'd0);
        check("mid_rst_ovf",   32'(overflow_o), 32'd0);
        check("mid_rst_addr",  l1d_waddr_o, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_we", 32'(l1d_we_o), 32'd0);

        // Push into a full buffer in the same cycle as a pop: accepted, no overflow.
        issue(mk(OP_S, 3'b010, 5'd0, 5'd7), 32'h500, 32'h6000, 32'h0, 1'b0, 1'b0);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd8), 32'h504, 32'h6004, 32'h0, 1'b0, 1'b0);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd9), 32'h508, 32'h6008, 32'h0, 1'b0, 1'b0);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd10), 32'h50C, 32'h600C, 32'h0, 1'b0, 1'b0);
        issue(mk(OP_S, 3'b010, 5'd0, 5'd11), 32'h510, 32'h6010, 32'h0, 1'b0, 1'b1);
        check("fullpop_ovf",  32'(overflow_o), 32'd0);
        check("fullpop_head", l1d_waddr_o, 32'h6004);
        step();
        check("fullpop_d1", l1d_waddr_o, 32'h6008);
        step();
        check("fullpop_d2", l1d_waddr_o, 32'h600C);
        step();
        check("fullpop_d3", l1d_waddr_o, 32'h6010);
        check("fullpop_d3_data", l1d_wdata_o, 32'h1122_3344);
        step();
        check("fullpop_empty", 32'(l1d_we_o), 32'd0);

`ifdef MEM_WB_STLF_EN
        issue(mk(OP_S, 3'b010, 5'd0, 5'd11), 32'h600, 32'h4000, 32'h0, 1'b0, 1'b0);
        issue(mk(OP_L, 3'b010, 5'd4, 5'd0), 32'h604, 32'h4000, 32'h0, 1'b0, 1'b0);
        check("stlf_lw", reg_wdata_o, 32'h1122_3344);
        issue(mk(OP_S, 3'b000, 5'd0, 5'd12), 32'h608, 32'h4001, 32'h0, 1'b0, 1'b0);
        issue(mk(OP_L, 3'b010, 5'd4, 5'd0), 32'h60C, 32'h4000, 32'h0, 1'b0, 1'b0);
        check("stlf_merge", reg_wdata_o, 32'h1122_5544);
        issue(mk(OP_L, 3'b000, 5'd4, 5'd0), 32'h610, 32'h4003, 32'h0, 1'b0, 1'b1);
        check("stlf_lb", reg_wdata_o, 32'h0000_0011);
        step(); step();
        check("stlf_drained", 32'(l1d_we_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
